// File: rtl/hdshk_pkg.sv
// Shared constants and helpers for the multi-channel handshake pulse synchroniser.
package hdshk_pkg;
  localparam int MODE_TOGGLE = 0;
  localparam int MODE_LEVEL  = 1;
  localparam int SYNC_MIN    = 2;

  // Largest value a pending-event counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction
endpackage

// File: rtl/hdshk_sync_chan.sv
// One receive channel: synchroniser chain, event detect, saturating pending
// counter with valid/ready drain, and sticky overflow flag.
module hdshk_sync_chan
  import hdshk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int CNT_W       = 4
) (
  input  logic clk_b,
  input  logic rst_n,
  input  logic sig_a,
  input  logic sig_b_ready,
  input  logic ovf_clr,
  output logic ack_a,
  output logic sig_b,
  output logic ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sig_b_q, sig_b_d;
  logic                   ovf_q, ovf_d;
  logic                   sync_out;
  logic                   ev;
  logic                   consume;
  logic                   ovf_set;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Handshake: an event is transferred on every edge where sig_b and
  // sig_b_ready are both high; sig_b is a flop so it never depends on ready.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_a};
    hist_d  = sync_out;
    ev      = (MODE == MODE_LEVEL) ? (sync_out & ~hist_q) : (sync_out ^ hist_q);
    consume = sig_b_q & sig_b_ready;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (ev && !consume) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + CNT_W'(1);
    end else if (!ev && consume) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    sig_b_d = (cnt_d != '0);
    // A new overflow wins over a same-cycle clear.
    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      sig_b_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      sig_b_q <= sig_b_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ack_a = sync_out;
  assign sig_b = sig_b_q;
  assign ovf   = ovf_q;
endmodule

// File: rtl/hdshk_pulse_sync_mc.sv
// Multi-channel destination-domain pulse synchroniser with handshake ack;
// each channel is an independent hdshk_sync_chan.
module hdshk_pulse_sync_mc
  import hdshk_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int CNT_W       = 4
) (
  input  logic          clk_b,
  input  logic          rst_n,
  input  logic [CH-1:0] sig_a,
  output logic [CH-1:0] ack_a,
  output logic [CH-1:0] sig_b,
  input  logic [CH-1:0] sig_b_ready,
  output logic [CH-1:0] ovf,
  input  logic [CH-1:0] ovf_clr
);
  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("hdshk_pulse_sync_mc: SYNC_STAGES must be >= 2");
  end
  if (MODE != MODE_TOGGLE && MODE != MODE_LEVEL) begin : g_bad_mode
    $error("hdshk_pulse_sync_mc: MODE must be 0 or 1");
  end
  if (CH < 1) begin : g_bad_ch
    $error("hdshk_pulse_sync_mc: CH must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    hdshk_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_b       (clk_b),
      .rst_n       (rst_n),
      .sig_a       (sig_a[i]),
      .sig_b_ready (sig_b_ready[i]),
      .ovf_clr     (ovf_clr[i]),
      .ack_a       (ack_a[i]),
      .sig_b       (sig_b[i]),
      .ovf         (ovf[i])
    );
  end
endmodule

// File: tb/tb_hdshk_pulse_sync_mc.sv
// Directed bench: toggle, level and narrow-counter instances share clock and reset.
module tb_hdshk_pulse_sync_mc;
  logic clk_b = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_b = ~clk_b;

  logic [3:0] sig_a_t = '0, rdy_t = '0, clr_t = '0, ack_t, vb_t, ovf_t;
  logic [3:0] sig_a_l = '0, rdy_l = '0, clr_l = '0, ack_l, vb_l, ovf_l;
  logic [3:0] sig_a_s = '0, rdy_s = '0, clr_s = '0, ack_s, vb_s, ovf_s;

  int checks = 0;
  int errors = 0;

  hdshk_pulse_sync_mc #(.CH(4), .SYNC_STAGES(2), .MODE(0), .CNT_W(4)) dut_t (
    .clk_b(clk_b), .rst_n(rst_n), .sig_a(sig_a_t), .ack_a(ack_t), .sig_b(vb_t),
    .sig_b_ready(rdy_t), .ovf(ovf_t), .ovf_clr(clr_t));
  hdshk_pulse_sync_mc #(.CH(4), .SYNC_STAGES(2), .MODE(1), .CNT_W(4)) dut_l (
    .clk_b(clk_b), .rst_n(rst_n), .sig_a(sig_a_l), .ack_a(ack_l), .sig_b(vb_l),
    .sig_b_ready(rdy_l), .ovf(ovf_l), .ovf_clr(clr_l));
  hdshk_pulse_sync_mc #(.CH(4), .SYNC_STAGES(2), .MODE(0), .CNT_W(2)) dut_s (
    .clk_b(clk_b), .rst_n(rst_n), .sig_a(sig_a_s), .ack_a(ack_s), .sig_b(vb_s),
    .sig_b_ready(rdy_s), .ovf(ovf_s), .ovf_clr(clr_s));

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  function automatic logic ack_of(input int inst, input int ch);
    case (inst)
      0:       return ack_t[ch];
      1:       return ack_l[ch];
      default: return ack_s[ch];
    endcase
  endfunction

  function automatic logic sig_of(input int inst, input int ch);
    case (inst)
      0:       return sig_a_t[ch];
      1:       return sig_a_l[ch];
      default: return sig_a_s[ch];
    endcase
  endfunction

  task automatic flip(input int inst, input int ch);
    case (inst)
      0:       sig_a_t[ch] = ~sig_a_t[ch];
      1:       sig_a_l[ch] = ~sig_a_l[ch];
      default: sig_a_s[ch] = ~sig_a_s[ch];
    endcase
  endtask

  task automatic wait_ack(input int inst, input int ch);
    int i = 0;
    while (i < 12 && ack_of(inst, ch) !== sig_of(inst, ch)) begin
      tick();
      i++;
    end
    checks++;
    if (ack_of(inst, ch) !== sig_of(inst, ch)) begin
      errors++;
      $display("FAIL wait_ack inst=%0d ch=%0d: ack=%b required %b", inst, ch,
               ack_of(inst, ch), sig_of(inst, ch));
    end
  endtask

  // One source request following the protocol, then one edge for the count.
  task automatic send_evt(input int inst, input int ch);
    flip(inst, ch);
    wait_ack(inst, ch);
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ack_t !== 4'h0) begin errors++; $display("FAIL reset ack_t: got %b required 0000", ack_t); end
    checks++; if (vb_t  !== 4'h0) begin errors++; $display("FAIL reset vb_t: got %b required 0000", vb_t); end
    checks++; if (ovf_t !== 4'h0) begin errors++; $display("FAIL reset ovf_t: got %b required 0000", ovf_t); end
    checks++; if (ack_l !== 4'h0) begin errors++; $display("FAIL reset ack_l: got %b required 0000", ack_l); end
    checks++; if (vb_l  !== 4'h0) begin errors++; $display("FAIL reset vb_l: got %b required 0000", vb_l); end
    checks++; if (ovf_s !== 4'h0) begin errors++; $display("FAIL reset ovf_s: got %b required 0000", ovf_s); end
    checks++; if (vb_s  !== 4'h0) begin errors++; $display("FAIL reset vb_s: got %b required 0000", vb_s); end
  endtask

  task automatic test_toggle_latency();
    sig_a_t[0] = 1'b1;
    tick();
    checks++; if (ack_t !== 4'b0000) begin errors++; $display("FAIL lat_edge0 ack: got %b required 0000", ack_t); end
    tick();
    checks++; if (ack_t !== 4'b0001) begin errors++; $display("FAIL lat_edge1 ack: got %b required 0001", ack_t); end
    checks++; if (vb_t  !== 4'b0000) begin errors++; $display("FAIL lat_edge1 sig_b: got %b required 0000", vb_t); end
    tick();
    checks++; if (vb_t  !== 4'b0001) begin errors++; $display("FAIL lat_edge2 sig_b: got %b required 0001", vb_t); end
    rdy_t[0] = 1'b1;
    tick();
    rdy_t[0] = 1'b0;
    checks++; if (vb_t  !== 4'b0000) begin errors++; $display("FAIL lat_drain sig_b: got %b required 0000", vb_t); end
  endtask

  task automatic test_level();
    for (int k = 0; k < 3; k++) begin
      sig_a_l[1] = 1'b1;
      wait_ack(1, 1);
      sig_a_l[1] = 1'b0;
      wait_ack(1, 1);
    end
    repeat (2) tick();
    checks++; if (vb_l !== 4'b0010) begin errors++; $display("FAIL level sig_b: got %b required 0010", vb_l); end
    rdy_l[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (vb_l[1] !== (k < 2)) begin
        errors++;
        $display("FAIL level_drain%0d sig_b[1]: got %b required %b", k, vb_l[1], (k < 2));
      end
    end
    rdy_l[1] = 1'b0;
  endtask

  task automatic drain_s2(input int exp_n, input string name);
    int n = 0;
    rdy_s[2] = 1'b1;
    for (int i = 0; i < 10 && vb_s[2]; i++) begin
      n++;
      tick();
    end
    rdy_s[2] = 1'b0;
    checks++;
    if (n !== exp_n) begin errors++; $display("FAIL %s handshakes: got %0d required %0d", name, n, exp_n); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      send_evt(2, 2);
      if (k == 2) begin
        checks++; if (ovf_s !== 4'b0000) begin errors++; $display("FAIL sat_pre ovf: got %b required 0000", ovf_s); end
      end
    end
    tick();
    checks++; if (ovf_s !== 4'b0100) begin errors++; $display("FAIL sat ovf: got %b required 0100", ovf_s); end
    checks++; if (vb_s  !== 4'b0100) begin errors++; $display("FAIL sat sig_b: got %b required 0100", vb_s); end
    clr_s[2] = 1'b1;
    tick();
    clr_s[2] = 1'b0;
    checks++; if (ovf_s !== 4'b0000) begin errors++; $display("FAIL sat_clr ovf: got %b required 0000", ovf_s); end
    drain_s2(3, "sat_drain");
  endtask

  task automatic test_simultaneous();
    repeat (3) send_evt(2, 2);
    flip(2, 2);
    tick();
    tick();
    rdy_s[2] = 1'b1;
    tick();
    rdy_s[2] = 1'b0;
    tick();
    checks++; if (ovf_s[2] !== 1'b0) begin errors++; $display("FAIL simul_full ovf[2]: got %b required 0", ovf_s[2]); end
    drain_s2(3, "simul_full");
    send_evt(2, 2);
    flip(2, 2);
    tick();
    tick();
    rdy_s[2] = 1'b1;
    tick();
    rdy_s[2] = 1'b0;
    checks++; if (vb_s[2] !== 1'b1) begin errors++; $display("FAIL simul_one sig_b[2]: got %b required 1", vb_s[2]); end
    drain_s2(1, "simul_one");
  endtask

  task automatic test_independence();
    sig_a_t[0] = ~sig_a_t[0];
    sig_a_t[3] = ~sig_a_t[3];
    wait_ack(0, 0);
    wait_ack(0, 3);
    tick();
    checks++; if (vb_t !== 4'b1001) begin errors++; $display("FAIL indep_both sig_b: got %b required 1001", vb_t); end
    rdy_t = 4'b0001;
    repeat (2) tick();
    rdy_t = 4'b0000;
    checks++; if (vb_t !== 4'b1000) begin errors++; $display("FAIL indep_hold sig_b: got %b required 1000", vb_t); end
    rdy_t[3] = 1'b1;
    tick();
    rdy_t[3] = 1'b0;
    checks++; if (vb_t !== 4'b0000) begin errors++; $display("FAIL indep_drain sig_b: got %b required 0000", vb_t); end
  endtask

  task automatic test_reset_mid();
    send_evt(0, 3);
    send_evt(0, 3);
    checks++; if (vb_t[3] !== 1'b1 || sig_a_t[3] !== 1'b1) begin errors++; $display("FAIL rst_pre sig_b[3]: got %b required 1", vb_t[3]); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (vb_t  !== 4'h0) begin errors++; $display("FAIL rst_async sig_b: got %b required 0000", vb_t); end
    checks++; if (ack_t !== 4'h0) begin errors++; $display("FAIL rst_async ack: got %b required 0000", ack_t); end
    checks++; if (ovf_t !== 4'h0) begin errors++; $display("FAIL rst_async ovf: got %b required 0000", ovf_t); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (vb_t  !== 4'b0000) begin errors++; $display("FAIL rst_edge1 sig_b: got %b required 0000", vb_t); end
    tick();
    checks++; if (ack_t !== 4'b1000) begin errors++; $display("FAIL rst_edge2 ack: got %b required 1000", ack_t); end
    checks++; if (vb_t  !== 4'b0000) begin errors++; $display("FAIL rst_edge2 sig_b: got %b required 0000", vb_t); end
    tick();
    checks++; if (vb_t  !== 4'b1000) begin errors++; $display("FAIL rst_edge3 sig_b: got %b required 1000", vb_t); end
    rdy_t[3] = 1'b1;
    tick();
    rdy_t[3] = 1'b0;
    checks++; if (vb_t  !== 4'b0000) begin errors++; $display("FAIL rst_single_event sig_b: got %b required 0000", vb_t); end
  endtask

  initial begin
    test_reset();
    test_toggle_latency();
    test_level();
    test_saturation();
    test_simultaneous();
    test_independence();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hdshk_pulse_sync_mc.md
Name: hdshk_pulse_sync_mc

Overview:
Multi-channel receive-side pulse synchroniser with handshake, clocked entirely in the destination domain. It is the parametrised successor to the single-channel clk_a→clk_b pulse synchroniser. Each channel takes an asynchronous request (toggle or four-phase level) from a foreign domain and synchronises it over a configurable depth. It queues detected events in a per-channel saturating counter, presents them under valid/ready, and returns a synchronised ack to the source.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
MODE, 0, request protocol: 0 = toggle (each level change is one event), 1 = four-phase level (rising edge only is one event)
CNT_W, 4, pending-event counter width per channel; max pending = 2^CNT_W-1

Ports:
clk_b  in  1  destination clock; all flops on rising edge
rst_n  in  1  asynchronous active-low reset; deassertion synchronous to clk_b by the integrator
sig_a  in  CH  asynchronous request per channel, driven from foreign domains
ack_a  out  CH  synchronised request echo, returned to the source as handshake ack
sig_b  out  CH  per-channel event valid (pending count != 0)
sig_b_ready  in  CH  per-channel consumer ready; one event consumed per cycle when sig_b & sig_b_ready
ovf  out  CH  sticky overflow: an event arrived while the counter was saturated
ovf_clr  in  CH  synchronous clear of ovf per channel

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, edge-history flops, counters, ack_a, sig_b and ovf go to 0. Events in flight are discarded.
- Sync chain: sig_a[i] → s[1] … s[SYNC_STAGES]. No logic between stages. ack_a[i] = s[SYNC_STAGES], registered.
- Edge history h[i] registers s[SYNC_STAGES].
- Event: MODE 0: ev = s[SYNC_STAGES] ^ h. MODE 1: ev = s[SYNC_STAGES] & ~h.
- Latency: a sig_a level meeting setup before rising edge k gives ack_a at edge k+SYNC_STAGES-1. The counter updates and sig_b rises at edge k+SYNC_STAGES (default: 3 edges including k).
- Counter per channel, in a single cycle:
  - ev only: cnt+1.
  - consume only (sig_b & sig_b_ready): cnt-1.
  - both: unchanged.
  - neither: unchanged.
- Saturation: ev with cnt = max and no consume keeps cnt = max and sets ovf the next edge. ev with cnt = max and consume at the same time is not an overflow.
- sig_b = (cnt != 0), registered from the counter, so it is never combinational from sig_b_ready. Consumption with sig_b low is ignored; cnt never underflows.
- ovf: set has priority over ovf_clr in the same cycle. Otherwise ovf_clr clears it at the next edge.
- Channels are fully independent. There is no cross-channel arbitration or ordering guarantee.
- Source rule MODE 0: toggle sig_a only when sig_a == ack_a. Back-to-back toggles faster than 2 destination cycles may merge, and this is not detected.
- Source rule MODE 1: raise sig_a, wait for ack_a high, drop sig_a, wait for ack_a low before the next request.
- Reset boundary: if sig_a is high when rst_n deasserts, the first synchronised 1 is counted as one event in both modes. Source and destination must therefore be reset together.
- sig_a glitches shorter than one clk_b period may or may not be captured. This is not specified.

Decomposition:
- Package hdshk_pkg holds:
  - MODE_TOGGLE = 0 and MODE_LEVEL = 1 constants
  - SYNC_MIN = 2
  - a per-channel counter-width function/typedef derived from CNT_W
- One sub-module, hdshk_sync_chan, covers a single channel: sync chain, edge detect, counter, ovf. The top level instantiates CH copies in a generate loop. The top also holds parameter legality checks: SYNC_STAGES >= 2, MODE in {0,1}, CH >= 1.

Test Plan:
- Toggle latency: CH=4, SYNC_STAGES=2, MODE=0, sig_b_ready=0. sig_a[0] 0→1 before edge 0 → ack_a[0]=1 after edge 1, sig_b[0]=1 after edge 2, cnt=1, other channels stay 0.
- Level mode: MODE=1, full four-phase cycle on ch1 (sig_a 1, wait ack 1, sig_a 0, wait ack 0) repeated 3× with ready=0 → cnt=3, falling edges not counted. Then ready=1 for 3 cycles → sig_b[1] low after the 3rd consume.
- Saturation/overflow: CNT_W=2, ready=0, 4 toggle events on ch2 → cnt=3, ovf[2]=1. Then ovf_clr pulse → ovf[2]=0. Drain → exactly 3 handshakes.
- Simultaneous event+consume: cnt=3 (saturated), event arrives in the same cycle as consume → cnt stays 3, ovf stays 0. With cnt=1, event+consume → cnt stays 1 and sig_b stays 1.
- Reset mid-operation: cnt=2 on ch3, sig_a[3]=1, pulse rst_n low asynchronously mid-cycle → sig_b, ack_a, ovf are 0 immediately. After deassertion, one event is counted on ch3 (sig_b[3]=1 at the 3rd edge).
- Independence: events on ch0 and ch3 on the same edge, ready only on ch0 → ch0 drains, ch3 holds cnt=1.
